// File: rtl/hls_rate_bridge_if.sv
// Host- and core-side handshake bundle of hls_rate_bridge.
// The master view is the bridge itself; the slave view is the surrounding I/O logic and core.
interface hls_rate_bridge_if #(
    parameter int WIDTH  = 18,
    parameter int NUM_CH = 3
);
    logic                    ap_start;
    logic                    in_vld;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic                    ap_done;
    logic                    ap_busy;
    logic [WIDTH-1:0]        out_data;
    logic                    out_vld;
    logic                    err_overrun;
    logic                    err_timeout;
    logic                    core_ce;
    logic                    core_start;
    logic                    core_in_vld;
    logic [NUM_CH*WIDTH-1:0] core_in_data;
    logic                    core_done;
    logic [WIDTH-1:0]        core_out;
    logic                    core_out_vld;

    modport master (
        input  ap_start, in_vld, in_data, core_done, core_out, core_out_vld,
        output ap_done, ap_busy, out_data, out_vld, err_overrun, err_timeout,
               core_ce, core_start, core_in_vld, core_in_data
    );

    modport slave (
        output ap_start, in_vld, in_data, core_done, core_out, core_out_vld,
        input  ap_done, ap_busy, out_data, out_vld, err_overrun, err_timeout,
               core_ce, core_start, core_in_vld, core_in_data
    );
endinterface

// File: rtl/hls_rate_bridge.sv
// Single-clock bridge to an HLS core ticking every DIV clk_1 cycles via core_ce.
// Optional RUN watchdog: define HLS_RATE_BRIDGE_TIMEOUT_EN (limit TIMEOUT_TICKS core ticks).
module hls_rate_bridge #(
    parameter int DIV           = 2,
    parameter int WIDTH         = 18,
    parameter int NUM_CH        = 3,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic               clk_1,
    input  logic               ap_rst,
    hls_rate_bridge_if.master  bus
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW    = NUM_CH * WIDTH;

    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             ce_p1;
    logic             start_p1, vld_p1;
    logic             start_edge, vld_edge;
    logic             pend_start, pend_vld;
    logic [DW-1:0]    in_data_p1;
    logic [WIDTH-1:0] out_data_p1;
    logic             out_vld_p1, done_p1;
    logic             overrun, timeout_flag;
    logic             accept, finish, to_hit;

    // Tick counter is free-running; core_ce is aligned with the DIV-1 phase.
    always_comb begin
        cnt_nx = cnt + 1'b1;
        if (cnt == CNT_W'(DIV - 1))
            cnt_nx = '0;
    end

    always_ff @(posedge clk_1 or posedge ap_rst) begin
        if (ap_rst) begin
            cnt   <= '0;
            ce_p1 <= 1'b0;
        end else begin
            cnt   <= cnt_nx;
            ce_p1 <= (cnt_nx == CNT_W'(DIV - 1));
        end
    end

    assign start_edge = bus.ap_start & ~start_p1;
    assign vld_edge   = bus.in_vld & ~vld_p1;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: if (start_edge) begin
                state_nx = ARMED;
                accept   = 1'b1;
            end
            ARMED: if (ce_p1) state_nx = RUN;
            RUN: if (ce_p1 && (bus.core_done || to_hit)) begin
                state_nx = IDLE;
                finish   = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request capture, result capture and sticky error flags.
    always_ff @(posedge clk_1 or posedge ap_rst) begin
        if (ap_rst) begin
            state       <= IDLE;
            start_p1    <= 1'b0;
            vld_p1      <= 1'b0;
            pend_start  <= 1'b0;
            pend_vld    <= 1'b0;
            in_data_p1  <= '0;
            out_data_p1 <= '0;
            out_vld_p1  <= 1'b0;
            done_p1     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state    <= state_nx;
            start_p1 <= bus.ap_start;
            vld_p1   <= bus.in_vld;
            if (accept) begin
                pend_start <= 1'b1;
                in_data_p1 <= bus.in_data;
            end else if (ce_p1) begin
                pend_start <= 1'b0;
            end
            // A fresh edge wins over the tick that consumes an older request.
            if (vld_edge && state != RUN)
                pend_vld <= 1'b1;
            else if (ce_p1)
                pend_vld <= 1'b0;
            if (start_edge && state != IDLE)
                overrun <= 1'b1;
            done_p1    <= finish;
            out_vld_p1 <= ce_p1 & bus.core_out_vld;
            if (ce_p1 && bus.core_out_vld)
                out_data_p1 <= bus.core_out;
        end
    end

`ifdef HLS_RATE_BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    logic [TO_W-1:0] to_cnt;

    // to_cnt holds the number of core ticks already spent in RUN.
    always_ff @(posedge clk_1 or posedge ap_rst) begin
        if (ap_rst) begin
            to_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state != RUN)
                to_cnt <= '0;
            else if (ce_p1)
                to_cnt <= to_cnt + 1'b1;
            if (state == RUN && ce_p1 && !bus.core_done && to_hit)
                timeout_flag <= 1'b1;
        end
    end

    assign to_hit = (to_cnt == TO_W'(TIMEOUT_TICKS - 1));
`else
    assign to_hit       = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    assign bus.core_ce      = ce_p1;
    assign bus.core_start   = pend_start;
    assign bus.core_in_vld  = pend_vld;
    assign bus.core_in_data = in_data_p1;
    assign bus.ap_done      = done_p1;
    assign bus.ap_busy      = (state != IDLE);
    assign bus.out_data     = out_data_p1;
    assign bus.out_vld      = out_vld_p1;
    assign bus.err_overrun  = overrun;
    assign bus.err_timeout  = timeout_flag;
endmodule

// File: tb/tb_hls_rate_bridge.sv
// Directed bench for hls_rate_bridge: cycle table at DIV=2 plus phase sweeps at DIV=1 and DIV=5.
module tb_hls_rate_bridge;
    localparam logic [53:0] D1 = {18'd3, 18'd2, 18'd1};
    localparam logic [53:0] D2 = {18'd5, 18'd6, 18'd7};
    localparam logic [53:0] D3 = {18'd9, 18'd9, 18'd9};
    localparam logic [53:0] D4 = {18'd4, 18'd4, 18'd4};

    logic clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 clk = ~clk;

    hls_rate_bridge_if #(.WIDTH(18), .NUM_CH(3)) i1 ();
    hls_rate_bridge_if #(.WIDTH(18), .NUM_CH(3)) i2 ();
    hls_rate_bridge_if #(.WIDTH(18), .NUM_CH(3)) i5 ();

    hls_rate_bridge #(.DIV(1), .WIDTH(18), .NUM_CH(3), .TIMEOUT_TICKS(8)) u1 (.clk_1(clk), .ap_rst(ap_rst), .bus(i1.master));
    hls_rate_bridge #(.DIV(2), .WIDTH(18), .NUM_CH(3), .TIMEOUT_TICKS(8)) u2 (.clk_1(clk), .ap_rst(ap_rst), .bus(i2.master));
    hls_rate_bridge #(.DIV(5), .WIDTH(18), .NUM_CH(3), .TIMEOUT_TICKS(8)) u5 (.clk_1(clk), .ap_rst(ap_rst), .bus(i5.master));

    typedef struct {
        logic        s, v, cd, cov;
        logic [17:0] co;
        logic [53:0] din;
        logic [6:0]  ec;   // {busy, ce, core_start, core_in_vld, ap_done, out_vld, err_overrun}
        logic [17:0] eo;
        logic [53:0] ecd;
    } vec_t;
    vec_t tbl [28];

    int n_tests = 0;
    int n_fail  = 0;
    int gap [3]  = '{0, 0, 0};
    int seen [3] = '{0, 0, 0};
    int wid [3]  = '{0, 0, 0};
    int perr [3] = '{0, 0, 0};
    int werr [3] = '{0, 0, 0};
    int ssmp [3] = '{0, 0, 0};
    int vsmp [3] = '{0, 0, 0};
    int ndone [3] = '{0, 0, 0};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ctrl2();
        return {i2.ap_busy, i2.core_ce, i2.core_start, i2.core_in_vld, i2.ap_done, i2.out_vld, i2.err_overrun};
    endfunction

    task automatic row(input int i, input logic s, input logic v, input logic cd, input logic cov,
                       input logic [17:0] co, input logic [6:0] ec);
        tbl[i].s   = s;
        tbl[i].v   = v;
        tbl[i].cd  = cd;
        tbl[i].cov = cov;
        tbl[i].co  = co;
        tbl[i].din = (i < 13) ? D1 : (i < 17) ? D2 : (i < 20) ? D3 : D4;
        tbl[i].ec  = ec;
        tbl[i].eo  = (i >= 11) ? 18'hABC : 18'h0;
        tbl[i].ecd = (i < 13) ? D1 : (i < 20) ? D2 : D4;
    endtask

    // Tick period, start-pulse width and sample counts, observed once per cycle.
    task automatic mon(input int k, input int div, input logic ce, input logic cs, input logic cv, input logic dn);
        if (ap_rst) begin
            gap[k] = 0; seen[k] = 0; wid[k] = 0;
        end else begin
            gap[k]++;
            if (ce) begin
                if (seen[k] != 0 && gap[k] != div) perr[k]++;
                gap[k] = 0;
                seen[k] = 1;
            end
            if (cs) begin
                wid[k]++;
                if (ce) ssmp[k]++;
            end else if (wid[k] != 0) begin
                if (wid[k] > div) werr[k]++;
                wid[k] = 0;
            end
            if (cv && ce) vsmp[k]++;
            if (dn) ndone[k]++;
        end
    endtask

    always @(negedge clk) begin
        mon(0, 1, i1.core_ce, i1.core_start, i1.core_in_vld, i1.ap_done);
        mon(1, 5, i5.core_ce, i5.core_start, i5.core_in_vld, i5.ap_done);
        mon(2, 2, i2.core_ce, i2.core_start, i2.core_in_vld, i2.ap_done);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    initial begin
        int dn, ov, got, base_d, base_s;
        logic [17:0] od;
        logic [53:0] cd;
        logic owv;

        i1.ap_start = 0; i1.in_vld = 0; i1.in_data = '0; i1.core_done = 1; i1.core_out = '0; i1.core_out_vld = 0;
        i5.ap_start = 0; i5.in_vld = 0; i5.in_data = '0; i5.core_done = 1; i5.core_out = '0; i5.core_out_vld = 0;
        i2.ap_start = 0; i2.in_vld = 0; i2.in_data = '0; i2.core_done = 0; i2.core_out = '0; i2.core_out_vld = 0;

        row( 0, 1, 0, 0, 0, 18'h0,   7'b1110000);
        row( 1, 0, 0, 0, 0, 18'h0,   7'b1000000);
        row( 2, 0, 0, 0, 0, 18'h0,   7'b1100000);
        row( 3, 0, 0, 0, 0, 18'h0,   7'b1000000);
        row( 4, 0, 0, 0, 0, 18'h0,   7'b1100000);
        row( 5, 0, 0, 0, 0, 18'h0,   7'b1000000);
        row( 6, 0, 0, 0, 0, 18'h0,   7'b1100000);
        row( 7, 0, 0, 0, 0, 18'h0,   7'b1000000);
        row( 8, 0, 0, 0, 0, 18'h0,   7'b1100000);
        row( 9, 0, 0, 0, 0, 18'h0,   7'b1000000);
        row(10, 0, 0, 1, 1, 18'h111, 7'b1100000);
        row(11, 0, 0, 1, 1, 18'hABC, 7'b0000110);
        row(12, 0, 0, 0, 0, 18'h0,   7'b0100000);
        row(13, 1, 1, 0, 0, 18'h0,   7'b1011000);
        row(14, 1, 1, 0, 0, 18'h0,   7'b1111000);
        row(15, 1, 1, 0, 0, 18'h0,   7'b1000000);
        row(16, 0, 0, 0, 0, 18'h0,   7'b1100000);
        row(17, 1, 1, 0, 0, 18'h0,   7'b1000001);
        row(18, 0, 0, 0, 0, 18'h0,   7'b1100001);
        row(19, 0, 0, 1, 0, 18'h0,   7'b0000101);
        row(20, 1, 0, 0, 0, 18'h0,   7'b1110001);
        row(21, 0, 0, 0, 0, 18'h0,   7'b1000001);
        row(22, 0, 0, 0, 0, 18'h0,   7'b1100001);
        row(23, 0, 0, 0, 0, 18'h0,   7'b1000001);
        row(24, 0, 0, 0, 0, 18'h0,   7'b1100001);
        row(25, 0, 0, 0, 0, 18'h0,   7'b1000001);
        row(26, 0, 0, 0, 0, 18'h0,   7'b1100001);
        row(27, 0, 0, 0, 0, 18'h0,   7'b1000001);

        repeat (2) @(negedge clk);
        chk("reset ctrl", 128'(ctrl2()), 128'(7'b0));
        chk("reset data", 128'({i2.out_data, i2.core_in_data, i2.err_timeout}), 128'(0));
        chk("reset ce div1", 128'(i1.core_ce), 128'(0));
        ap_rst = 0;

        // Nominal run, simultaneous edges, overrun, done plus new start, then 3 ticks into RUN.
        for (int i = 0; i < 28; i++) begin
            i2.ap_start = tbl[i].s;
            i2.in_vld = tbl[i].v;
            i2.in_data = tbl[i].din;
            i2.core_done = tbl[i].cd;
            i2.core_out_vld = tbl[i].cov;
            i2.core_out = tbl[i].co;
            @(negedge clk);
            chk($sformatf("row%0d ctrl", i), 128'(ctrl2()), 128'(tbl[i].ec));
            chk($sformatf("row%0d data", i), 128'({i2.out_data, i2.core_in_data}), 128'({tbl[i].eo, tbl[i].ecd}));
        end
        chk("table start samples", 128'(ssmp[2]), 128'(3));
        chk("table vld samples", 128'(vsmp[2]), 128'(1));
        chk("table done pulses", 128'(ndone[2]), 128'(2));

        #2 ap_rst = 1;
        #1;
        chk("async reset ctrl", 128'(ctrl2()), 128'(7'b0));
        chk("async reset data", 128'({i2.out_data, i2.core_in_data}), 128'(0));
        repeat (2) @(negedge clk);
        ap_rst = 0;

        // Restart after reset, with a core that finishes on its first RUN tick.
        i2.in_data = D1; i2.core_out = 18'h2A5; i2.ap_start = 1;
        got = 0; od = '0; owv = 0; cd = '0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (j == 0) i2.ap_start = 0;
            if (i2.ap_done) begin
                got = 1; od = i2.out_data; owv = i2.out_vld; cd = i2.core_in_data;
                break;
            end
            i2.core_done = i2.ap_busy & ~i2.core_start;
            i2.core_out_vld = i2.ap_busy & ~i2.core_start;
        end
        i2.core_done = 0; i2.core_out_vld = 0;
        chk("restart done", 128'(got), 128'(1));
        chk("restart out", 128'({owv, od, cd}), 128'({1'b1, 18'h2A5, D1}));
        chk("restart overrun", 128'(i2.err_overrun), 128'(0));

        // Held start level: one request only.
        repeat (3) @(negedge clk);
        base_d = ndone[2]; base_s = ssmp[2];
        i2.ap_start = 1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            i2.core_done = i2.ap_busy & ~i2.core_start;
        end
        i2.ap_start = 0; i2.core_done = 0;
        repeat (6) @(negedge clk);
        chk("held done count", 128'(ndone[2] - base_d), 128'(1));
        chk("held start samples", 128'(ssmp[2] - base_s), 128'(1));
        chk("held overrun", 128'(i2.err_overrun), 128'(0));

        // Core never finishes.
        i2.ap_start = 1;
        @(negedge clk);
        i2.ap_start = 0;
        dn = 0; ov = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (j == 11) chk("timeout not early", 128'(i2.ap_busy), 128'(1));
            if (i2.ap_done) dn++;
            if (i2.out_vld) ov++;
        end
`ifdef HLS_RATE_BRIDGE_TIMEOUT_EN
        chk("timeout done", 128'(dn), 128'(1));
        chk("timeout out_vld", 128'(ov), 128'(0));
        chk("timeout flag", 128'({i2.err_timeout, i2.ap_busy}), 128'(2'b10));
`else
        chk("no timeout done", 128'(dn), 128'(0));
        chk("no timeout busy", 128'({i2.err_timeout, i2.ap_busy}), 128'(2'b01));
`endif
        ap_rst = 1;
        repeat (2) @(negedge clk);
        ap_rst = 0;
        chk("flags cleared", 128'({i2.err_timeout, i2.err_overrun}), 128'(0));

        // Start edges on every counter phase for DIV=1 and DIV=5.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            i1.ap_start = 1; i5.ap_start = 1;
            @(negedge clk);
            i1.ap_start = 0; i5.ap_start = 0;
            for (int j = 0; j < 40 && (i1.ap_busy || i5.ap_busy); j++) @(negedge clk);
            chk($sformatf("sweep%0d idle", k), 128'({i1.ap_busy, i5.ap_busy}), 128'(0));
            repeat (k) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        chk("div1 done count", 128'(ndone[0]), 128'(10));
        chk("div5 done count", 128'(ndone[1]), 128'(10));
        chk("div1 start samples", 128'(ssmp[0]), 128'(10));
        chk("div5 start samples", 128'(ssmp[1]), 128'(10));
        chk("div1 ce period", 128'(perr[0]), 128'(0));
        chk("div5 ce period", 128'(perr[1]), 128'(0));
        chk("div2 ce period", 128'(perr[2]), 128'(0));
        chk("start width", 128'({werr[0], werr[1], werr[2]}), 128'(0));
        chk("sweep overrun", 128'({i1.err_overrun, i5.err_overrun}), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
